// File: rtl/pipeline_stall_ctrl.sv
// Stall-bus producer: zero-latency priority arbitration of stage stall requests
// plus run-length, total-cycle and hang-watchdog bookkeeping.
module pipeline_stall_ctrl #(
   parameter int CNT_W   = 32,
   parameter int RUN_W   = 16,
   parameter int TIMEOUT = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stallreq_from_id,
   input  logic             stallreq_from_ex,
   input  logic             stallreq_from_mem,
   input  logic             clr_i,
   output logic [5:0]       stall,
   output logic [1:0]       stall_src_o,
   output logic [CNT_W-1:0] stall_cycles_o,
   output logic [RUN_W-1:0] cur_run_o,
   output logic [RUN_W-1:0] max_run_o,
   output logic             timeout_o
);

   typedef enum logic [1:0] {
      S_RUN,
      S_STALLED,
      S_HUNG
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [RUN_W-1:0] RUN_MAX = '1;
   localparam logic [RUN_W-1:0] TMO     = RUN_W'(TIMEOUT);

   state_t           state_q;
   state_t           state_d;
   logic [1:0]       src;
   logic             any_req;
   logic [RUN_W-1:0] run_nxt;
   logic             run_hit;
   logic             fsm_hung;

   // Encodings keep the stopped prefix contiguous so one bubble forms
   always_comb begin
      stall = 6'b000000;
      src   = 2'd0;
      unique case (1'b1)
         stallreq_from_mem: begin
            stall = 6'b011111;
            src   = 2'd3;
         end
         stallreq_from_ex & ~stallreq_from_mem: begin
            stall = 6'b001111;
            src   = 2'd2;
         end
         stallreq_from_id & ~stallreq_from_ex
            & ~stallreq_from_mem: begin
            stall = 6'b000111;
            src   = 2'd1;
         end
         default: ;
      endcase
   end

   assign any_req = (src != 2'd0);

   always_comb begin
      run_nxt = '0;
      if (any_req) begin
         run_nxt = (cur_run_o == RUN_MAX) ? cur_run_o
                 : cur_run_o + RUN_W'(1);
      end
   end

   assign run_hit = (run_nxt == TMO);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RUN: begin
            if (any_req) state_d = S_STALLED;
         end
         S_STALLED: begin
            if (!any_req) state_d = S_RUN;
            else if (run_hit && !clr_i) state_d = S_HUNG;
         end
         S_HUNG: begin
            if (clr_i) state_d = any_req ? S_STALLED : S_RUN;
         end
         default: state_d = S_RUN;
      endcase
   end

   always_comb begin
      fsm_hung = (state_q == S_HUNG);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_src_o    <= 2'd0;
         stall_cycles_o <= '0;
         cur_run_o      <= '0;
         max_run_o      <= '0;
         timeout_o      <= 1'b0;
      end else begin
         stall_src_o <= src;
         if (clr_i) begin
            stall_cycles_o <= '0;
            cur_run_o      <= '0;
            max_run_o      <= '0;
            timeout_o      <= 1'b0;
         end else begin
            if (any_req && stall_cycles_o != CNT_MAX) begin
               stall_cycles_o <= stall_cycles_o + CNT_W'(1);
            end
            cur_run_o <= run_nxt;
            if (run_nxt > max_run_o) max_run_o <= run_nxt;
            // A hung FSM always implies the flag; keep it asserted while hung
            timeout_o <= timeout_o | run_hit | fsm_hung;
         end
      end
   end

endmodule
